bitwise_stim: RTL

Operand stimulus generator that sits directly upstream of the combinational `bitwise` unit and drives its `a`/`b` operand inputs. On `start`, it emits a complete sequence of operand pairs over a valid/ready handshake, so the consumer can apply back-pressure. The sequence is either an exhaustive sweep or a maximal-length LFSR sequence. The block reports progress (`busy`, `last`, `count`) and pulses `done` at the end.

---
 rtl/bitwise_stim.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bitwise_stim.sv
// Operand stimulus generator for the bitwise unit: emits an exhaustive or LFSR
// sequence of (a, b) pairs over a valid/ready handshake.
module bitwise_stim #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [2*WIDTH-1:0]   seed,
    input  logic                 ready,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 valid,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     count
);

    localparam int unsigned SW = 2 * WIDTH;
    localparam int unsigned CW = SW + 1;

    // Maximal-length Fibonacci taps for the supported state widths.
    localparam logic [7:0]    TapsAll = (SW == 8) ? 8'hB8 : (SW == 6) ? 8'h30 : 8'h0C;
    localparam logic [SW-1:0] Taps    = TapsAll[SW-1:0];

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          st_q, st_d;
    logic [SW-1:0]   s_q, s_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            done_q, done_d;

    logic            fb;
    logic [SW-1:0]   s_next;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   last_idx;

    always_comb begin
        fb       = ^(s_q & Taps);
        s_next   = mode_q ? {s_q[SW-2:0], fb} : s_q + SW'(1);
        cnt_inc  = cnt_q + CW'(1);
        // Index of the final pair: P-1, with P = 2^SW or 2^SW-1.
        last_idx = mode_q ? {1'b0, {(SW-1){1'b1}}, 1'b0} : {1'b0, {SW{1'b1}}};
    end

    always_comb begin
        st_d    = st_q;
        s_d     = s_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    st_d    = StRun;
                    mode_d  = mode;
                    s_d     = mode ? ((seed == '0) ? SW'(1) : seed) : '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            StRun: begin
                if (ready) begin
                    s_d   = s_next;
                    cnt_d = cnt_inc;
                    if (last_q) begin
                        st_d    = StDone;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        last_d = (cnt_inc == last_idx);
                    end
                end
            end
            StDone: begin
                st_d = StIdle;
            end
            default: begin
                st_d    = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            s_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            s_q     <= s_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign a     = s_q[SW-1:WIDTH];
    assign b     = s_q[WIDTH-1:0];
    assign valid = valid_q;
    assign last  = last_q;
    assign busy  = (st_q == StRun);
    assign done  = done_q;
    assign count = cnt_q;

endmodule
